// File: rtl/parking_pkg.sv
// Shared constants for the parking zone controller: default capacities,
// the daily reallocation schedule and the car class encoding.
package parking_pkg;

  localparam int DEF_CNT_W          = 10;
  localparam int DEF_TOTAL_CAP      = 700;
  localparam int DEF_UNI_CAP        = 500;
  localparam int DEF_TICKS_PER_HOUR = 60;
  localparam int DEF_START_HOUR     = 8;
  localparam int DEF_SHIFT_HOUR_A   = 14;
  localparam int DEF_SHIFT_HOUR_B   = 15;
  localparam int DEF_RESTORE_HOUR   = 16;
  localparam int DEF_SHIFT_STEP     = 50;
  localparam int DEF_UNI_FLOOR      = 200;

  typedef enum logic {
    CLASS_PUB = 1'b0,
    CLASS_UNI = 1'b1
  } car_class_e;

  function automatic logic [4:0] next_hour(input logic [4:0] h);
    if (h == 5'd23) begin
      return 5'd0;
    end else begin
      return h + 5'd1;
    end
  endfunction

endpackage

// File: rtl/parking_hour_gen.sv
// Simulated clock: divides clk into hours and strobes hour_wrap on the
// cycle whose edge advances the hour.
module parking_hour_gen
  import parking_pkg::*;
#(
  parameter int TICKS_PER_HOUR = DEF_TICKS_PER_HOUR,
  parameter int START_HOUR     = DEF_START_HOUR
) (
  input  logic       clk,
  input  logic       rst,
  output logic [4:0] hour,
  output logic       hour_wrap
);

  localparam int TICK_W = (TICKS_PER_HOUR > 1) ? $clog2(TICKS_PER_HOUR) : 1;
  localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(TICKS_PER_HOUR - 1);

  logic [TICK_W-1:0] tick_r;

  assign hour_wrap = (tick_r == TICK_LAST);

  // Tick counter and hour register.
  always_ff @(posedge clk) begin
    if (rst) begin
      tick_r <= {TICK_W{1'b0}};
      hour   <= 5'(START_HOUR);
    end else if (hour_wrap) begin
      tick_r <= {TICK_W{1'b0}};
      hour   <= next_hour(hour);
    end else begin
      tick_r <= tick_r + TICK_W'(1'b1);
      hour   <= hour;
    end
  end

endmodule

// File: rtl/parking_zone_ctrl.sv
// Two-pool (uni/public) parking occupancy controller with a simulated clock.
// Define PARKING_REALLOC_EN to build in the afternoon capacity reallocation.
module parking_zone_ctrl
  import parking_pkg::*;
#(
  parameter int CNT_W          = DEF_CNT_W,
  parameter int TOTAL_CAP      = DEF_TOTAL_CAP,
  parameter int UNI_CAP        = DEF_UNI_CAP,
  parameter int TICKS_PER_HOUR = DEF_TICKS_PER_HOUR,
  parameter int START_HOUR     = DEF_START_HOUR,
  parameter int SHIFT_HOUR_A   = DEF_SHIFT_HOUR_A,
  parameter int SHIFT_HOUR_B   = DEF_SHIFT_HOUR_B,
  parameter int RESTORE_HOUR   = DEF_RESTORE_HOUR,
  parameter int SHIFT_STEP     = DEF_SHIFT_STEP,
  parameter int UNI_FLOOR      = DEF_UNI_FLOOR
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             enter_valid,
  input  logic             enter_is_uni,
  input  logic             exit_valid,
  input  logic             exit_is_uni,
  output logic             enter_accept,
  output logic             enter_reject,
  output logic             exit_reject,
  output logic [CNT_W-1:0] uni_parked,
  output logic [CNT_W-1:0] pub_parked,
  output logic [CNT_W-1:0] uni_free,
  output logic [CNT_W-1:0] pub_free,
  output logic [CNT_W-1:0] uni_cap,
  output logic             uni_has_space,
  output logic             pub_has_space,
  output logic [4:0]       hour
);

  localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0] TOTAL_C  = CNT_W'(TOTAL_CAP);
  localparam logic [CNT_W-1:0] UNI_C    = CNT_W'(UNI_CAP);
  localparam logic [CNT_W-1:0] PUB_C    = CNT_W'(TOTAL_CAP - UNI_CAP);

  typedef struct packed {
    logic [CNT_W-1:0] parked;
    logic [CNT_W-1:0] free;
  } pool_t;

  // An exit only returns a space when the pool was not over-committed by a restore.
  function automatic pool_t pool_step(input pool_t p, input logic [CNT_W-1:0] cap,
                                      input logic ent, input logic ext);
    pool_t n;
    n = p;
    case ({ent, ext})
      2'b10: begin
        n.parked = p.parked + CNT_ONE;
        n.free   = p.free - CNT_ONE;
      end
      2'b01: begin
        n.parked = p.parked - CNT_ONE;
        if (p.parked <= cap) begin
          n.free = p.free + CNT_ONE;
        end else begin
          n.free = p.free;
        end
      end
      default: n = p;
    endcase
    return n;
  endfunction

  logic [4:0]       hour_s;
  logic             hour_wrap_s;
  logic             ent_uni_s, ent_pub_s, ext_uni_s, ext_pub_s;
  logic             ent_ok_s, ext_ok_s;
  logic [CNT_W-1:0] pub_cap_s;
  logic [CNT_W-1:0] uni_cap_n_s;
  pool_t            uni_n_s, pub_n_s;

  parking_hour_gen #(
    .TICKS_PER_HOUR(TICKS_PER_HOUR),
    .START_HOUR    (START_HOUR)
  ) u_hour_gen (
    .clk      (clk),
    .rst      (rst),
    .hour     (hour_s),
    .hour_wrap(hour_wrap_s)
  );

  assign hour      = hour_s;
  assign pub_cap_s = TOTAL_C - uni_cap;

  // Accept/reject decisions from the counts registered before this edge.
  always_comb begin
    ent_uni_s = enter_valid && (enter_is_uni == CLASS_UNI) && (uni_free != CNT_ZERO);
    ent_pub_s = enter_valid && (enter_is_uni == CLASS_PUB) && (pub_free != CNT_ZERO);
    ext_uni_s = exit_valid && (exit_is_uni == CLASS_UNI) && (uni_parked != CNT_ZERO);
    ext_pub_s = exit_valid && (exit_is_uni == CLASS_PUB) && (pub_parked != CNT_ZERO);
    ent_ok_s  = ent_uni_s || ent_pub_s;
    ext_ok_s  = ext_uni_s || ext_pub_s;
  end

`ifdef PARKING_REALLOC_EN
  localparam logic [4:0]       HOUR_A_C = 5'(SHIFT_HOUR_A);
  localparam logic [4:0]       HOUR_B_C = 5'(SHIFT_HOUR_B);
  localparam logic [4:0]       HOUR_R_C = 5'(RESTORE_HOUR);
  localparam logic [CNT_W-1:0] STEP_C   = CNT_W'(SHIFT_STEP);
  localparam logic [CNT_W-1:0] FLOOR_C  = CNT_W'(UNI_FLOOR);

  logic [4:0]       hour_n_s;
  logic [CNT_W-1:0] shift_d_s;
  logic [CNT_W-1:0] pub_cap_n_s;
`else
  logic [31:0] unused_sched_s;
  assign unused_sched_s = 32'(SHIFT_HOUR_A ^ SHIFT_HOUR_B ^ RESTORE_HOUR ^ SHIFT_STEP ^ UNI_FLOOR)
                        ^ {31'd0, hour_wrap_s};
`endif

  // Next pool state: car events first, then any reallocation on the hour wrap.
  always_comb begin
    uni_n_s     = pool_step({uni_parked, uni_free}, uni_cap, ent_uni_s, ext_uni_s);
    pub_n_s     = pool_step({pub_parked, pub_free}, pub_cap_s, ent_pub_s, ext_pub_s);
    uni_cap_n_s = uni_cap;
`ifdef PARKING_REALLOC_EN
    hour_n_s    = next_hour(hour_s);
    shift_d_s   = (uni_n_s.free < STEP_C) ? uni_n_s.free : STEP_C;
    pub_cap_n_s = pub_cap_s;
    if (hour_wrap_s && ((hour_n_s == HOUR_A_C) || (hour_n_s == HOUR_B_C))) begin
      uni_cap_n_s  = uni_cap - shift_d_s;
      uni_n_s.free = uni_n_s.free - shift_d_s;
      pub_n_s.free = pub_n_s.free + shift_d_s;
    end else if (hour_wrap_s && (hour_n_s == HOUR_R_C)) begin
      uni_cap_n_s  = (uni_n_s.parked > FLOOR_C) ? uni_n_s.parked : FLOOR_C;
      pub_cap_n_s  = TOTAL_C - uni_cap_n_s;
      uni_n_s.free = uni_cap_n_s - uni_n_s.parked;
      pub_n_s.free = (pub_n_s.parked >= pub_cap_n_s) ? CNT_ZERO
                                                     : (pub_cap_n_s - pub_n_s.parked);
    end else begin
      uni_cap_n_s = uni_cap;
    end
`endif
  end

  // Output registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      enter_accept  <= 1'b0;
      enter_reject  <= 1'b0;
      exit_reject   <= 1'b0;
      uni_parked    <= CNT_ZERO;
      pub_parked    <= CNT_ZERO;
      uni_free      <= UNI_C;
      pub_free      <= PUB_C;
      uni_cap       <= UNI_C;
      uni_has_space <= 1'b1;
      pub_has_space <= 1'b1;
    end else begin
      enter_accept  <= ent_ok_s;
      enter_reject  <= enter_valid && !ent_ok_s;
      exit_reject   <= exit_valid && !ext_ok_s;
      uni_parked    <= uni_n_s.parked;
      pub_parked    <= pub_n_s.parked;
      uni_free      <= uni_n_s.free;
      pub_free      <= pub_n_s.free;
      uni_cap       <= uni_cap_n_s;
      uni_has_space <= (uni_n_s.free != CNT_ZERO);
      pub_has_space <= (pub_n_s.free != CNT_ZERO);
    end
  end

endmodule
